// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Elastic valid/ready pipeline register with a 2-entry skid buffer,
//            registered in_ready, synchronous flush and saturating drop count.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            count,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    // State bits are {main_valid, skid_valid}; (0,1) has no encoding.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b10,
        S_FULL  = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [DATA_WIDTH-1:0] w_main_nxt;
    logic [DATA_WIDTH-1:0] w_skid_nxt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic                  w_main_valid;
    logic                  w_skid_valid;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic [1:0]            w_drop_add;
    logic [CNT_WIDTH+1:0]  w_drop_sum;
    logic [CNT_WIDTH-1:0]  w_drop_sat;

    assign w_main_valid = r_state[1];
    assign w_skid_valid = r_state[0];
    assign w_in_xfer    = in_valid & in_ready;
    assign w_out_xfer   = out_valid & out_ready;

    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;
    assign count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
    assign drop_cnt  = r_drop_cnt;

    // Entries lost to a flush: the head unless it leaves this cycle, the skid
    // entry, and any beat accepted in the same cycle.
    assign w_drop_add = {1'b0, w_main_valid & ~w_out_xfer}
                      + {1'b0, w_skid_valid}
                      + {1'b0, w_in_xfer};
    assign w_drop_sum = {2'b00, r_drop_cnt} + {{CNT_WIDTH{1'b0}}, w_drop_add};
    assign w_drop_sat = (|w_drop_sum[CNT_WIDTH+1:CNT_WIDTH]) ? c_cnt_max
                                                             : w_drop_sum[CNT_WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_main_nxt  = in_data;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_nxt = in_data;
                end else if (w_in_xfer) begin
                    w_skid_nxt  = in_data;
                    w_state_nxt = S_FULL;
                end else if (w_out_xfer) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_xfer) begin
                    w_main_nxt  = r_skid_data;
                    w_state_nxt = S_BUSY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush clears validity only; the data registers keep their contents.
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = r_main_data;
            w_skid_nxt  = r_skid_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_main_data <= RESET_VAL;
            r_skid_data <= RESET_VAL;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
            if (flush) begin
                r_drop_cnt <= w_drop_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Directed vector table, saturation sequence and queue-model run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam logic [31:0] c_rv = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  count;
    logic [7:0]  drop_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_count;
    logic [1:0]  s_drop_cnt;

    logic        n_in_ready, n_out_valid;
    logic [0:0]  n_out_data;
    logic [1:0]  n_count;
    logic [7:0]  n_drop_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_WIDTH(32), .RESET_VAL(c_rv), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count), .drop_cnt(drop_cnt)
    );

    pipe_skid_reg #(.DATA_WIDTH(32), .RESET_VAL(c_rv), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(out_ready), .count(s_count), .drop_cnt(s_drop_cnt)
    );

    pipe_skid_reg #(.DATA_WIDTH(1), .RESET_VAL(1'b1), .CNT_WIDTH(8)) u_narrow (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data[0:0]),
        .in_ready(n_in_ready), .out_valid(n_out_valid), .out_data(n_out_data),
        .out_ready(out_ready), .count(n_count), .drop_cnt(n_drop_cnt)
    );

    typedef struct {
        logic        rst_n, flush, iv;
        logic [31:0] din;
        logic        ordy;
        logic        e_ir, e_ov;
        logic [31:0] e_data;
        logic [1:0]  e_cnt;
        logic [7:0]  e_drop;
        logic [1:0]  e_dsat;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] d, logic o,
                                logic ir, logic ov, logic [31:0] ed, logic [1:0] ec,
                                logic [7:0] edr, logic [1:0] eds);
        vec_t v;
        v.rst_n = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = o;
        v.e_ir = ir; v.e_ov = ov; v.e_data = ed; v.e_cnt = ec;
        v.e_drop = edr; v.e_dsat = eds;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic o);
        rst_n = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
        @(posedge clk);
        #1;
    endtask

    // The (main_valid=0, skid_valid=1) state shows as out_valid=0 with in_ready=0.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (!out_valid && !in_ready) begin
                errors++;
                $display("FAIL illegal_state: out_valid=0 in_ready=0 at %0t", $time);
            end
        end
    end

    initial begin
        int          q[$];
        logic [31:0] m_data;
        int          m_drop, m_dsat, seq, d;
        bit          ix, ox;
        logic        p_ov, p_or, p_fl, p_rst;
        logic [31:0] p_data;
        int          sat_exp[4];

        tbl[0]  = mk(0,0,0,32'h0 ,0, 1,0,c_rv ,0,0,0);
        tbl[1]  = mk(0,0,1,32'h99,1, 1,0,c_rv ,0,0,0);
        tbl[2]  = mk(1,0,0,32'h0 ,1, 1,0,c_rv ,0,0,0);
        tbl[3]  = mk(1,0,1,32'h1 ,1, 1,1,32'h1 ,1,0,0);
        tbl[4]  = mk(1,0,1,32'h2 ,1, 1,1,32'h2 ,1,0,0);
        tbl[5]  = mk(1,0,1,32'h3 ,1, 1,1,32'h3 ,1,0,0);
        tbl[6]  = mk(1,0,0,32'h0 ,1, 1,0,32'h3 ,0,0,0);
        tbl[7]  = mk(1,0,1,32'h11,0, 1,1,32'h11,1,0,0);
        tbl[8]  = mk(1,0,1,32'h22,0, 0,1,32'h11,2,0,0);
        tbl[9]  = mk(1,0,1,32'h77,0, 0,1,32'h11,2,0,0);
        tbl[10] = mk(1,0,0,32'h0 ,1, 1,1,32'h22,1,0,0);
        tbl[11] = mk(1,0,0,32'h0 ,1, 1,0,32'h22,0,0,0);
        tbl[12] = mk(1,0,1,32'h11,0, 1,1,32'h11,1,0,0);
        tbl[13] = mk(1,0,1,32'h22,0, 0,1,32'h11,2,0,0);
        tbl[14] = mk(1,1,1,32'h55,0, 1,0,32'h11,0,2,2);
        tbl[15] = mk(1,0,1,32'h33,0, 1,1,32'h33,1,2,2);
        tbl[16] = mk(1,1,1,32'h44,1, 1,0,32'h33,0,3,3);
        tbl[17] = mk(1,0,0,32'h0 ,0, 1,0,32'h33,0,3,3);
        tbl[18] = mk(1,0,1,32'h66,0, 1,1,32'h66,1,3,3);
        tbl[19] = mk(1,0,1,32'h67,0, 0,1,32'h66,2,3,3);
        tbl[20] = mk(0,1,1,32'h68,1, 1,0,c_rv ,0,0,0);
        tbl[21] = mk(1,0,0,32'h0 ,0, 1,0,c_rv ,0,0,0);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rst_n, tbl[i].flush, tbl[i].iv, tbl[i].din, tbl[i].ordy);
            chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("v%0d_out_data", i),  out_data,           tbl[i].e_data);
            chk($sformatf("v%0d_count", i),     {30'd0, count},     {30'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_drop", i),      {24'd0, drop_cnt},  {24'd0, tbl[i].e_drop});
            chk($sformatf("v%0d_drop_sat", i),  {30'd0, s_drop_cnt},{30'd0, tbl[i].e_dsat});
            chk_en = 1'b1;
        end

        // Four flushes from FULL, two entries lost each time.
        sat_exp[0] = 2; sat_exp[1] = 3; sat_exp[2] = 3; sat_exp[3] = 3;
        step(0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 1, 32'hA0 + k, 0);
            step(1, 0, 1, 32'hB0 + k, 0);
            chk($sformatf("sat%0d_full_count", k), {30'd0, count}, 32'd2);
            step(1, 1, 0, 32'h0, 0);
            chk($sformatf("sat%0d_drop_sat", k), {30'd0, s_drop_cnt}, sat_exp[k]);
            chk($sformatf("sat%0d_drop", k), {24'd0, drop_cnt}, 2 * (k + 1));
            chk($sformatf("sat%0d_out_data", k), out_data, 32'hA0 + k);
        end

        // Random traffic against a queue model.
        step(0, 0, 0, 32'h0, 0);
        m_data = c_rv; m_drop = 0; m_dsat = 0; seq = 1;
        p_ov = 1'b0; p_or = 1'b1; p_fl = 1'b0; p_rst = 1'b0; p_data = '0;
        for (int c = 0; c < 1000; c++) begin
            chk("rnd_out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
            chk("rnd_in_ready",  {31'd0, in_ready},  (q.size() < 2) ? 32'd1 : 32'd0);
            chk("rnd_count",     {30'd0, count},     q.size());
            chk("rnd_out_data",  out_data, m_data);
            chk("rnd_drop",      {24'd0, drop_cnt},  m_drop);
            chk("rnd_drop_sat",  {30'd0, s_drop_cnt}, m_dsat);
            chk("rnd_sat_data",  s_out_data, m_data);
            chk("rnd_sat_ctl",   {28'd0, s_in_ready, s_out_valid, s_count},
                {28'd0, in_ready, out_valid, count});
            chk("rnd_narrow",    {29'd0, n_in_ready, n_out_valid, n_out_data},
                {29'd0, (q.size() < 2) ? 1'b1 : 1'b0, (q.size() > 0) ? 1'b1 : 1'b0, m_data[0]});
            chk("rnd_narrow_drop", {24'd0, n_drop_cnt}, m_drop);
            if (p_rst && !p_fl && p_ov && !p_or) begin
                chk("rnd_stall_valid", {31'd0, out_valid}, 32'd1);
                chk("rnd_stall_data", out_data, p_data);
            end
            rst_n     = !(c >= 500 && c < 502);
            flush     = ($urandom_range(0, 99) < 5);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 1) == 1);
            in_data   = seq;
            seq++;
            p_ov = out_valid; p_or = out_ready; p_fl = flush; p_rst = rst_n; p_data = out_data;
            if (!rst_n) begin
                q.delete();
                m_data = c_rv; m_drop = 0; m_dsat = 0;
            end else begin
                ix = in_valid && (q.size() < 2);
                ox = out_ready && (q.size() > 0);
                if (ox) void'(q.pop_front());
                if (flush) begin
                    d = q.size() + (ix ? 1 : 0);
                    m_drop = (m_drop + d > 255) ? 255 : m_drop + d;
                    m_dsat = (m_dsat + d > 3) ? 3 : m_dsat + d;
                    q.delete();
                end else begin
                    if (ix) q.push_back(in_data);
                    if (q.size() > 0) m_data = q[0];
                end
            end
            @(posedge clk);
            #1;
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline register that succeeds the plain free-running flop stage.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer so in_ready is purely registered, a synchronous flush, and a parametrised reset value.
- Sits between RISC-V pipeline stages (IF/ID, ID/EX, ...) so a stage can stall or be squashed without combinational ready paths spanning stages.
- Sustains one transfer per cycle.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- RESET_VAL, 0 (DATA_WIDTH bits), value driven on out_data after reset.
- CNT_WIDTH, 8, width of the saturating flush-drop counter.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream payload valid.
- in_data  input  DATA_WIDTH  upstream payload.
- in_ready  output  1  block can accept; equals NOT skid_valid, driven only from flops.
- out_valid  output  1  out_data holds a valid entry.
- out_data  output  DATA_WIDTH  head entry (main register).
- out_ready  input  1  downstream accepts.
- count  output  2  occupancy, 0..2.
- drop_cnt  output  CNT_WIDTH  saturating count of entries discarded by flush.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Definitions:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Storage is the main register (main_data, main_valid) and the skid register (skid_data, skid_valid).
- Reset (rst_n=0 at posedge):
  - main_valid=0, skid_valid=0, out_data=RESET_VAL, skid_data=RESET_VAL, drop_cnt=0.
  - Resulting outputs: in_ready=1, out_valid=0, count=0.
  - Reset overrides flush and all transfers, including mid-operation with FULL occupancy.
- States are encoded by (main_valid, skid_valid):
  - EMPTY = (0,0).
  - BUSY = (1,0).
  - FULL = (1,1).
  - (0,1) is illegal and never reached.
- Transitions, each applied at posedge when not in reset and not flushing:
  - EMPTY, in_xfer: main <= in_data, go to BUSY.
  - EMPTY, no in_xfer: stay in EMPTY.
  - BUSY, in_xfer & out_xfer: main <= in_data, stay in BUSY.
  - BUSY, in_xfer only: skid <= in_data, go to FULL. in_ready falls the next cycle.
  - BUSY, out_xfer only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL: in_ready=0, so no in_xfer is possible.
  - FULL, out_xfer: main <= skid_data, skid_valid <= 0, go to BUSY.
  - FULL, no out_xfer: hold.
- Latency and ordering:
  - An entry accepted at edge N is visible on out_valid/out_data after edge N (1 cycle).
  - Entries exit strictly in acceptance order.
- Stable output: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- Flush (flush=1 at posedge, rst_n=1):
  - main_valid <= 0 and skid_valid <= 0, so next state is EMPTY.
  - A beat presented with in_xfer in the flush cycle is discarded.
  - An out_xfer occurring in the same cycle still counts as delivered downstream.
  - out_data retains its value; only valid is cleared.
- drop_cnt:
  - On a flush, add (main_valid & ~out_xfer) + skid_valid + in_xfer, which ranges 0..3.
  - Saturate at 2^CNT_WIDTH-1 and never wrap.
  - Cleared only by reset.
- count:
  - main_valid + skid_valid, from flops.
  - Mid-cycle in-flight beats are not counted.
- Empty data: while out_valid=0, out_data holds its last value (RESET_VAL after reset). Consumers must ignore it.
- Combinational paths: no combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Widths: all data paths are exactly DATA_WIDTH. DATA_WIDTH=1 must elaborate.

Test Plan:
- Reset + streaming: RESET_VAL=32'hDEAD_BEEF; hold rst_n=0 for 2 cycles, then release. Require out_data=DEAD_BEEF, out_valid=0, in_ready=1. Then send 1,2,3 back-to-back with out_ready=1: they appear on consecutive cycles, each 1 cycle after acceptance; count stays at 1; in_ready stays 1.
- Stall/skid fill: out_ready=0, send A=0x11 then B=0x22. Require count=2, in_ready=0, out_data=0x11 stable. Raise out_ready: outputs 0x11 then 0x22, in_ready returns to 1 one cycle after 0x11 leaves.
- Flush in FULL with a beat present: state FULL (0x11, 0x22), out_ready=0, in_valid=1, flush=1. Require EMPTY next cycle, drop_cnt=2 (the input beat is not accepted because in_ready=0), out_valid=0, out_data=0x11.
- Flush in BUSY with concurrent transfers: BUSY holding 0x33, out_ready=1, in_valid=1 with 0x44, flush=1. Require 0x33 delivered, 0x44 dropped, drop_cnt +1, EMPTY next cycle.
- Saturation with CNT_WIDTH=2: four flushes that each drop 2 entries. Require drop_cnt sequence 2, 3, 3, 3.
- Random backpressure: 1000 cycles of random in_valid/out_ready/flush at 5%, with rst_n pulsed mid-run. Scoreboard checks order, no duplication, and that the drop count matches; assert the (0,1) state never occurs and out_data is stable under stall.
